// File: rtl/alu_arbiter.sv
// Purpose : shares one single-cycle integer ALU between NUM_REQ valid/ready requesters.
// Latency : result registered on the accept edge; rsp_valid_o is high from the next cycle.
// Backpr. : one-deep response register; while the owner stalls, no request is accepted.
//
// Ports:
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o per-requester request handshake
//   req_op1_i/req_op2_i     per-requester 32-bit operands
//   req_funct7_i/funct3_i   per-requester operation select (NORMAL/ALT + funct3)
//   rsp_valid_o/rsp_ready_i per-requester response handshake, only the owner's bit is live
//   rsp_result_o            held result, shared, qualified by rsp_valid_o
//
// Option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration through rr_q;
//         otherwise fixed priority (lowest valid index wins).

package alu_pkg;
  typedef enum logic [6:0] {
    ALU_F7_NORMAL = 7'h00,
    ALU_F7_ALT    = 7'h20
  } alu_funct7_e;

  typedef enum logic [2:0] {
    ALU_F3_ADD  = 3'd0,
    ALU_F3_SLL  = 3'd1,
    ALU_F3_SLT  = 3'd2,
    ALU_F3_SLTU = 3'd3,
    ALU_F3_XOR  = 3'd4,
    ALU_F3_SRL  = 3'd5,
    ALU_F3_OR   = 3'd6,
    ALU_F3_AND  = 3'd7
  } alu_funct3_e;
endpackage

// Purpose : single-cycle 32-bit integer ALU.
// Latency : purely combinational.
// Backpr. : none; unsupported funct7/funct3 pairs produce 32'h0.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  alu_funct7_e funct7_i,
  input  alu_funct3_e funct3_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;
  assign shamt = op2_i[4:0];

  always_comb begin
    result_o = 32'h0;
    if (funct7_i == ALU_F7_NORMAL) begin
      case (funct3_i)
        ALU_F3_ADD:  result_o = op1_i + op2_i;
        ALU_F3_SLL:  result_o = op1_i << shamt;
        ALU_F3_SLT:  result_o = {31'h0, $signed(op1_i) < $signed(op2_i)};
        ALU_F3_SLTU: result_o = {31'h0, op1_i < op2_i};
        ALU_F3_XOR:  result_o = op1_i ^ op2_i;
        ALU_F3_SRL:  result_o = op1_i >> shamt;
        ALU_F3_OR:   result_o = op1_i | op2_i;
        ALU_F3_AND:  result_o = op1_i & op2_i;
        default:     result_o = 32'h0;
      endcase
    end else if (funct7_i == ALU_F7_ALT) begin
      // Only SUB and SRA exist in the ALT space.
      case (funct3_i)
        ALU_F3_ADD: result_o = op1_i - op2_i;
        ALU_F3_SRL: result_o = $unsigned($signed(op1_i) >>> shamt);
        default:    result_o = 32'h0;
      endcase
    end
  end

endmodule

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][31:0]      req_op1_i,
  input  logic [NUM_REQ-1:0][31:0]      req_op2_i,
  input  alu_funct7_e [NUM_REQ-1:0]     req_funct7_i,
  input  alu_funct3_e [NUM_REQ-1:0]     req_funct3_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [31:0]                   rsp_result_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {ST_IDLE, ST_FULL} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] own_q;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             rsp_fire;
  logic             accept;
  logic [31:0]      result_q;
  logic [31:0]      alu_result;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_q;
  assign rr_ptr = rr_q;

  // The winner drops to lowest priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (accept) begin
      rr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // Scan from the priority pointer with wrap-around; the first valid index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int               idx;
      logic [IDX_W-1:0] cand;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // A new request may land on the same edge the held result is consumed.
  assign rsp_fire = (state_q == ST_FULL) && rsp_ready_i[own_q];
  assign accept   = grant_vld && ((state_q == ST_IDLE) || rsp_fire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)        state_d = ST_FULL;
    else if (rsp_fire) state_d = ST_IDLE;
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (accept)                req_ready_o[grant_idx] = 1'b1;
    if (state_q == ST_FULL)    rsp_valid_o[own_q]     = 1'b1;
  end

  alu u_alu (
    .op1_i    (req_op1_i[grant_idx]),
    .op2_i    (req_op2_i[grant_idx]),
    .funct7_i (req_funct7_i[grant_idx]),
    .funct3_i (req_funct3_i[grant_idx]),
    .result_o (alu_result)
  );

  // Result and owner only change on accept; a release leaves the old value visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= 32'h0;
      own_q    <= '0;
    end else if (accept) begin
      result_q <= alu_result;
      own_q    <= grant_idx;
    end
  end

  assign rsp_result_o = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : self-checking bench for alu_arbiter (NUM_REQ=2).
// Latency : checks comb handshakes at negedge, registered results the cycle after accept.
// Backpr. : exercises owner stalls, non-owner ready bits and mid-cycle async reset.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N-1:0]         req_valid_i;
  logic [N-1:0]         req_ready_o;
  logic [N-1:0][31:0]   req_op1_i;
  logic [N-1:0][31:0]   req_op2_i;
  alu_funct7_e [N-1:0]  req_funct7_i;
  alu_funct3_e [N-1:0]  req_funct3_i;
  logic [N-1:0]         rsp_valid_o;
  logic [N-1:0]         rsp_ready_i;
  logic [31:0]          rsp_result_o;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op1_i    (req_op1_i),
    .req_op2_i    (req_op2_i),
    .req_funct7_i (req_funct7_i),
    .req_funct3_i (req_funct3_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    alu_funct7_e f7;
    alu_funct3_e f3;
    logic [31:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input vec_t v);
    req_op1_i[k]    = v.op1;
    req_op2_i[k]    = v.op2;
    req_funct7_i[k] = v.f7;
    req_funct3_i[k] = v.f3;
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    rsp_ready_i = '0;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  // One isolated request through channel k; starts and ends at posedge+1 with block IDLE.
  task automatic single_op(input int k, input vec_t v, input string name);
    set_req(k, v);
    req_valid_i[k] = 1'b1;
    rsp_ready_i    = '0;
    @(negedge clk_i);
    check({name, " ready"}, 32'(req_ready_o), 32'(1 << k));
    @(posedge clk_i); #1;
    req_valid_i[k] = 1'b0;
    rsp_ready_i[k] = 1'b1;
    @(negedge clk_i);
    check({name, " rsp_valid"}, 32'(rsp_valid_o), 32'(1 << k));
    check({name, " result"}, rsp_result_o, v.exp);
    @(posedge clk_i); #1;
    rsp_ready_i = '0;
    @(negedge clk_i);
    check({name, " idle"}, 32'(rsp_valid_o), 32'h0);
    @(posedge clk_i); #1;
  endtask

  // Reference ALU expressed with plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input alu_funct7_e f7, input alu_funct3_e f3);
    int unsigned sh;
    longint      pw;
    longint      sa;
    longint      q;
    logic [31:0] r;
    sh = b % 32;
    pw = longint'(1) << sh;
    sa = longint'(int'(a));
    r  = 32'h0;
    if (f7 == ALU_F7_NORMAL) begin
      case (f3)
        ALU_F3_ADD:  r = 32'((longint'(a) + longint'(b)) % (longint'(1) << 32));
        ALU_F3_SLL:  r = 32'((longint'(a) * pw) % (longint'(1) << 32));
        ALU_F3_SLT:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        ALU_F3_SLTU: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
        ALU_F3_XOR:  r = a ^ b;
        ALU_F3_SRL:  r = 32'(longint'(a) / pw);
        ALU_F3_OR:   r = a | b;
        ALU_F3_AND:  r = a & b;
        default:     r = 32'h0;
      endcase
    end else if (f7 == ALU_F7_ALT) begin
      if (f3 == ALU_F3_ADD) begin
        r = 32'((longint'(a) - longint'(b) + (longint'(1) << 32)) % (longint'(1) << 32));
      end else if (f3 == ALU_F3_SRL) begin
        // Floor division of the signed value.
        q = sa / pw;
        if (sa < 0 && (sa % pw) != 0) q = q - 1;
        r = 32'(q);
      end
    end
    return r;
  endfunction

  vec_t vecs[14];
  vec_t v_sub, v_sra, v_add;

  // Model state for the random phase.
  int          m_ptr;
  bit          m_have;
  int          m_owner;
  logic [31:0] m_res;
  bit          m_pend [N];
  bit          m_outst[N];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    req_valid_i = '0;
    rsp_ready_i = '0;
    req_op1_i   = '0;
    req_op2_i   = '0;
    for (int k = 0; k < N; k++) begin
      req_funct7_i[k] = ALU_F7_NORMAL;
      req_funct3_i[k] = ALU_F3_ADD;
    end

    vecs[0]  = '{32'd5,        32'd3,        ALU_F7_NORMAL, ALU_F3_ADD,  32'h8};
    vecs[1]  = '{32'd3,        32'd5,        ALU_F7_ALT,    ALU_F3_ADD,  32'hFFFFFFFE};
    vecs[2]  = '{32'h80000000, 32'd4,        ALU_F7_ALT,    ALU_F3_SRL,  32'hF8000000};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, ALU_F7_ALT,    ALU_F3_AND,  32'h0};
    vecs[4]  = '{32'hFFFFFFFF, 32'h1,        ALU_F7_NORMAL, ALU_F3_SLT,  32'h1};
    vecs[5]  = '{32'hFFFFFFFF, 32'h1,        ALU_F7_NORMAL, ALU_F3_SLTU, 32'h0};
    vecs[6]  = '{32'h1,        32'd31,       ALU_F7_NORMAL, ALU_F3_SLL,  32'h80000000};
    vecs[7]  = '{32'h80000000, 32'h24,       ALU_F7_NORMAL, ALU_F3_SRL,  32'h08000000};
    vecs[8]  = '{32'hF0F0F0F0, 32'hFF00FF00, ALU_F7_NORMAL, ALU_F3_XOR,  32'h0FF00FF0};
    vecs[9]  = '{32'h0F0F0000, 32'h000000F0, ALU_F7_NORMAL, ALU_F3_OR,   32'h0F0F00F0};
    vecs[10] = '{32'h12345678, 32'h0000FFFF, ALU_F7_NORMAL, ALU_F3_AND,  32'h00005678};
    vecs[11] = '{32'h1,        32'h1,        ALU_F7_ALT,    ALU_F3_SLL,  32'h0};
    vecs[12] = '{32'h1,        32'hFFFFFFFF, ALU_F7_NORMAL, ALU_F3_SLT,  32'h0};
    vecs[13] = '{32'h1,        32'hFFFFFFFF, ALU_F7_NORMAL, ALU_F3_SLTU, 32'h1};

    v_sub = vecs[1];
    v_sra = vecs[2];
    v_add = vecs[0];

    // Reset state.
    #2;
    check("reset req_ready", 32'(req_ready_o), 32'h0);
    check("reset rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("reset result", rsp_result_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post-reset rsp_valid", 32'(rsp_valid_o), 32'h0);
    @(posedge clk_i); #1;

    // Table of ALU operations, alternating requester.
    for (int i = 0; i < 14; i++) begin
      single_op(i % 2, vecs[i], $sformatf("vec%0d", i));
    end

    // Contention with both consumers ready.
    do_reset();
    set_req(0, v_sub);
    set_req(1, v_sra);
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b11;
    @(negedge clk_i);
    check("cont first grant", 32'(req_ready_o), 32'h1);
    @(posedge clk_i); #1;
    req_valid_i[0] = 1'b0;
    @(negedge clk_i);
    check("cont second grant", 32'(req_ready_o), 32'h2);
    check("cont rsp0 valid", 32'(rsp_valid_o), 32'h1);
    check("cont rsp0 result", rsp_result_o, 32'hFFFFFFFE);
    @(posedge clk_i); #1;
    req_valid_i[1] = 1'b0;
    @(negedge clk_i);
    check("cont rsp1 valid", 32'(rsp_valid_o), 32'h2);
    check("cont rsp1 result", rsp_result_o, 32'hF8000000);
    @(posedge clk_i); #1;
    req_valid_i = 2'b11;
    @(negedge clk_i);
    check("cont wrap grant", 32'(req_ready_o), 32'h1);
    @(posedge clk_i); #1;
    req_valid_i[0] = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i[1] = 1'b0;
    @(posedge clk_i); #1;
    rsp_ready_i = '0;
    @(negedge clk_i);
    check("cont drained", 32'(rsp_valid_o), 32'h0);

    // req0 alone, then both: the pointer now favours req1 in round-robin mode.
    @(posedge clk_i); #1;
    set_req(0, v_add);
    req_valid_i = 2'b01;
    rsp_ready_i = 2'b11;
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    @(posedge clk_i); #1;
    req_valid_i = 2'b11;
    @(negedge clk_i);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    check("rr after req0", 32'(req_ready_o), 32'h2);
`else
    check("fixed after req0", 32'(req_ready_o), 32'h1);
`endif
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    @(posedge clk_i); #1;

    // Backpressure: owner stalls three cycles, non-owner ready is ignored.
    do_reset();
    set_req(0, v_sub);
    set_req(1, v_sra);
    req_valid_i = 2'b11;
    @(negedge clk_i);
    check("bp first grant", 32'(req_ready_o), 32'h1);
    @(posedge clk_i); #1;
    req_valid_i[0] = 1'b0;
    rsp_ready_i    = 2'b10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("bp stall%0d ready", c), 32'(req_ready_o), 32'h0);
      check($sformatf("bp stall%0d valid", c), 32'(rsp_valid_o), 32'h1);
      check($sformatf("bp stall%0d result", c), rsp_result_o, 32'hFFFFFFFE);
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 2'b01;
    @(negedge clk_i);
    check("bp release grant", 32'(req_ready_o), 32'h2);
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b10;
    @(negedge clk_i);
    check("bp rsp1 valid", 32'(rsp_valid_o), 32'h2);
    check("bp rsp1 result", rsp_result_o, 32'hF8000000);
    @(posedge clk_i); #1;
    rsp_ready_i = '0;

    // Asynchronous reset while FULL.
    set_req(0, '{32'd7, 32'd9, ALU_F7_NORMAL, ALU_F3_ADD, 32'h10});
    req_valid_i = 2'b01;
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    @(negedge clk_i);
    check("ar full valid", 32'(rsp_valid_o), 32'h1);
    check("ar full result", rsp_result_o, 32'h10);
    #2;
    rst_ni = 1'b0;
    #1;
    check("ar drop valid", 32'(rsp_valid_o), 32'h0);
    check("ar clear result", rsp_result_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    single_op(0, v_add, "ar after");

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr = 0; m_have = 0; m_owner = 0; m_res = 32'h0;
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 0;
      m_outst[k] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int          g;
      bit          can;
      bit          consumed;
      logic [31:0] exp_rdy;
      logic [31:0] exp_vld;
      for (int k = 0; k < N; k++) begin
        if (!m_pend[k] && !m_outst[k] && $urandom_range(0, 2) == 0) begin
          m_pend[k]       = 1;
          req_op1_i[k]    = $urandom;
          req_op2_i[k]    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
          req_funct7_i[k] = ($urandom_range(0, 3) == 0) ? ALU_F7_ALT : ALU_F7_NORMAL;
          req_funct3_i[k] = alu_funct3_e'($urandom_range(0, 7));
        end
        req_valid_i[k] = m_pend[k];
      end
      rsp_ready_i = N'($urandom_range(0, (1 << N) - 1));

      can = !m_have || rsp_ready_i[m_owner];
      g = -1;
      if (can) begin
        for (int i = 0; i < N; i++) begin
          if (g < 0 && m_pend[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
      end
      exp_rdy = (g >= 0) ? 32'(1 << g) : 32'h0;
      exp_vld = m_have ? 32'(1 << m_owner) : 32'h0;

      @(negedge clk_i);
      check($sformatf("rand%0d ready", cyc), 32'(req_ready_o), exp_rdy);
      check($sformatf("rand%0d valid", cyc), 32'(rsp_valid_o), exp_vld);
      if (m_have) check($sformatf("rand%0d result", cyc), rsp_result_o, m_res);
      @(posedge clk_i); #1;

      consumed = m_have && rsp_ready_i[m_owner];
      if (consumed) begin
        m_outst[m_owner] = 0;
        m_have = 0;
      end
      if (g >= 0) begin
        m_have   = 1;
        m_owner  = g;
        m_res    = ref_alu(req_op1_i[g], req_op2_i[g], req_funct7_i[g], req_funct3_i[g]);
        m_pend[g]  = 0;
        m_outst[g] = 1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        m_ptr = (g + 1) % N;
`endif
      end
    end
    req_valid_i = '0;
    rsp_ready_i = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer `alu` between `NUM_REQ` requesters, e.g. the execute stage and the address/branch helper paths. Each requester gets a valid/ready request channel and a valid/ready response channel. The block arbitrates among the pending requests, drives the winning operands and function codes into one internal `alu` instance, and captures the result in a one-deep response register tagged with the owner. Results are returned in order; only one operation is in flight at a time.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `clk_i` input, 1 bit: clock, rising edge.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `req_valid_i` input, `NUM_REQ` bits: request valid, one bit per requester.
- `req_ready_o` output, `NUM_REQ` bits: request accepted this cycle.
- `req_op1_i` input, `[NUM_REQ-1:0][31:0]`: operand 1 per requester.
- `req_op2_i` input, `[NUM_REQ-1:0][31:0]`: operand 2 per requester.
- `req_funct7_i` input, `NUM_REQ` x `alu_funct7_e`: NORMAL/ALT selector.
- `req_funct3_i` input, `NUM_REQ` x `alu_funct3_e`: operation select.
- `rsp_valid_o` output, `NUM_REQ` bits: result valid; at most one bit is set, the owner's.
- `rsp_ready_i` input, `NUM_REQ` bits: requester accepts the result.
- `rsp_result_o` output, 32 bits: held result, shared by all requesters and qualified by `rsp_valid_o`.

## Operation
- **Two states.**
  - IDLE: no result is held.
  - FULL: the response register holds a result, its owner index `own_q`, and `rsp_valid_o[own_q]`=1.
- **Grant.** Computed combinationally from `req_valid_i` and the priority pointer `rr_q`.
  - The first valid requester at or after `rr_q`, in index order with wrap-around, wins.
  - At most one grant exists per cycle.
- **Accept.** `req_ready_o[g]`=1 only for the granted requester `g`, and only when the block is in IDLE or the held result is being consumed this cycle (`rsp_valid_o[own_q] & rsp_ready_i[own_q]`).
  - All other `req_ready_o` bits are 0.
- **On accept.**
  - The ALU output for requester `g`'s operands is registered into `rsp_result_o`.
  - `own_q` is set to `g`, and the state becomes or stays FULL.
  - `rr_q` is set to `(g+1) mod NUM_REQ`.
- **Release.** A response handshake with no accept in the same cycle moves the state to IDLE. `rsp_result_o` keeps its last value.
- **ALU function.** Identical to `alu`:
  - ADD, SUB (ALT+ADD), AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA (ALT+SRL).
  - Shifts use `op2[4:0]`.
  - Any unsupported funct7/funct3 pair yields 32'h0 and is still accepted and returned.
- **Requester rules.**
  - Once `req_valid_i[k]` is asserted, it must stay high and its payload must stay stable until `req_ready_o[k]`.
  - A requester must not issue a new request before its previous response has been accepted. Violating this is a protocol error; the block does not check for it.
- `rsp_ready_i` bits of non-owners are ignored.

## Timing
- **Reset values.**
  - `req_ready_o`=0.
  - `rsp_valid_o`=0 and `rsp_result_o`=32'h0.
  - State IDLE, `rr_q`=0, `own_q`=0.
  - Reset asserted mid-operation discards the held result immediately, with no handshake.
- **Latency.** A request accepted on rising edge N produces `rsp_valid_o` high after edge N, so the result is visible in the cycle following accept.
- **Throughput.** One operation per cycle when the owner holds `rsp_ready_i` high. A back-to-back accept and release on the same edge is required behaviour.
- **Stalls.** While FULL and the owner has `rsp_ready_i`=0, all `req_ready_o` are 0 and `rsp_result_o`/`own_q` stay stable.
- **Combinational paths.** `req_ready_o` depends combinationally on `req_valid_i`, `rsp_ready_i` and state. There is no combinational path from `req_op*_i` to any output.
- **Simultaneous requests.** Each winner moves to lowest priority, so no requester waits more than `NUM_REQ`-1 grants.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration through `rr_q`, as described above.
- `ALU_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the lowest valid index always wins.
  - `rr_q` is not implemented and is treated as constant 0.
  - Higher indices may starve; all other behaviour is unchanged.

## Test plan
- **Single ADD.** Reset, then req0 ADD with op1=5, op2=3. Required response: `req_ready_o[0]`=1 in the same cycle, then `rsp_valid_o`=01 and result 32'h8 in the next cycle. After `rsp_ready_i[0]`=1 the block returns to IDLE.
- **Round-robin contention.** req0 SUB 3-5 and req1 SRA 32'h80000000 by 4 are valid together, with both `rsp_ready_i` high. Required response: req0 is granted first with result 32'hFFFFFFFE, then req1 on the next cycle with result 32'hF8000000. If both re-request, req0 wins again (pointer wrap). Without the macro, req0 always wins first.
- **Backpressure.** Same stimulus with the owner's `rsp_ready_i`=0 for 3 cycles. Required response: result and `own_q` held, no `req_ready_o` asserted; the pending request is accepted on the release edge.
- **Unsupported op.** ALT with AND on 32'hFFFFFFFF, 32'hFFFFFFFF. Required response: accepted, result 32'h0.
- **Async reset while FULL.** Pulse `rst_ni` low mid-cycle while FULL. Required response: `rsp_valid_o` drops immediately, and the next request is returned normally.
- **SLT vs SLTU.** SLT on 32'hFFFFFFFF, 32'h1 returns 1; SLTU on the same operands returns 0; SLL of 1 by 31 returns 32'h80000000.
